// File: rtl/pipe_result_fifo.sv
// Result capture for the 3-stage arithmetic pipeline: a delayed issue strobe
// writes F into a first-word-fall-through FIFO with ready/valid output and sticky overflow.
module pipe_result_fifo #(
    parameter int N     = 10,
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue,
    input  logic [N-1:0]                 F,
    output logic [N-1:0]                 out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [LAT-1:0] trk_q, trk_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [N-1:0]   mem_q [DEPTH];

    logic wr, rd, full_w, wr_acc;

    // The pipeline has no valid bit, so issue is delayed by its latency here.
    if (LAT == 1) begin : g_trk_one
        assign trk_d = issue;
    end else begin : g_trk_many
        assign trk_d = {trk_q[LAT-2:0], issue};
    end

    always_comb begin
        wr     = trk_q[LAT-1];
        full_w = (count_q == CW'(DEPTH));
        rd     = (count_q != '0) && out_ready;
        // A read on the same edge frees the slot, so a full FIFO still accepts.
        wr_acc = wr && (!full_w || rd);

        count_d = count_q;
        case ({wr_acc, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | (wr && !wr_acc);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            trk_q      <= trk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so
    // stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= F;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign full      = full_w;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipe_result_fifo.sv
// Directed bench for pipe_result_fifo: a queue-based model checked every cycle,
// plus hand-computed expectations for latency, ordering, full, gaps and reset.
module tb_pipe_result_fifo;

    localparam int N     = 10;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue = 1'b0;
    logic [N-1:0]  F = '0;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_result_fifo #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .issue(issue), .F(F),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: issues are remembered by edge number and become writes LAT edges later.
    int      edge_n = 0;
    int      issue_times[$];
    int      exp_q[$];
    bit      exp_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_times.delete();
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            int  sz;
            bit  m_wr, m_rd;
            m_wr = (issue_times.size() > 0) && (issue_times[0] == edge_n - LAT);
            if (m_wr) void'(issue_times.pop_front());
            if (issue) issue_times.push_back(edge_n);
            sz   = exp_q.size();
            m_rd = (sz > 0) && out_ready;
            if (m_rd) void'(exp_q.pop_front());
            if (m_wr) begin
                if (sz < DEPTH || m_rd) exp_q.push_back(int'(F));
                else exp_ovf = 1'b1;
            end
        end
        edge_n++;
    end

    always @(negedge clk) begin
        check("m_valid", out_valid, exp_q.size() != 0);
        check("m_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 0);
        check("m_count", count, exp_q.size());
        check("m_full", full, exp_q.size() == DEPTH);
        check("m_ovf", overflow, exp_ovf);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit iss, input int f, input bit rdy);
        issue     = iss;
        F         = N'(f);
        out_ready = rdy;
        step();
    endtask

    task automatic do_reset();
        issue = 1'b0; out_ready = 1'b0; F = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t2_f[6] = '{15, 70, 288, 1, 2, 3};
        bit gap_pat[5] = '{1, 0, 1, 1, 0};
        int gap_cnt[8] = '{0, 0, 0, 1, 1, 2, 3, 3};
        int gap_f;

        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);

        // Latency: issue at edge 0, F=15 presented at edge 3.
        cyc(1, 0, 0);
        cyc(0, 500, 0); check("lat_e1_valid", out_valid, 0);
        cyc(0, 500, 0); check("lat_e2_valid", out_valid, 0);
        cyc(0, 15, 0);
        check("lat_e3_valid", out_valid, 1);
        check("lat_e3_data", out_data, 15);
        check("lat_e3_count", count, 1);
        cyc(0, 77, 0);  check("lat_hold_count", count, 1);
        cyc(0, 0, 1);   check("lat_drain_count", count, 0);

        // Ordering and pointer wrap with the consumer always ready from edge 4.
        for (int i = 0; i < 9; i++) begin
            cyc(i < 6, (i >= 3) ? t2_f[i-3] : 0, i >= 4);
            if (i >= 3) check("ord_data", out_data, t2_f[i-3]);
        end
        cyc(0, 0, 1);
        check("ord_empty", out_valid, 0);
        check("ord_ovf", overflow, 0);

        // Full with a simultaneous read on the fifth write edge.
        for (int i = 0; i < 8; i++) begin
            cyc(i < 5, (i >= 3) ? (i - 2) * 10 : 0, i == 7);
            if (i == 6) begin
                check("fsr_e6_count", count, 4);
                check("fsr_e6_full", full, 1);
            end
        end
        check("fsr_count", count, 4);
        check("fsr_full", full, 1);
        check("fsr_ovf", overflow, 0);
        check("fsr_head", out_data, 20);
        cyc(0, 0, 1); check("fsr_d1", out_data, 30);
        cyc(0, 0, 1); check("fsr_d2", out_data, 40);
        cyc(0, 0, 1); check("fsr_last", out_data, 50);
        cyc(0, 0, 1); check("fsr_empty", out_valid, 0);

        // Full without a read: fifth result is dropped.
        for (int i = 0; i < 8; i++) begin
            cyc(i < 5, (i >= 3) ? 100 + i - 2 : 0, 0);
            if (i == 6) check("ovf_e6_ovf", overflow, 0);
        end
        check("ovf_count", count, 4);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_head", out_data, 101);
        cyc(0, 0, 0);   check("ovf_sticky", overflow, 1);

        do_reset();
        check("rst2_ovf", overflow, 0);

        // Gapped issues 1,0,1,1,0 -> writes at edges 3, 5, 6.
        for (int i = 0; i < 8; i++) begin
            case (i)
                3: gap_f = 7;
                4: gap_f = 555;
                5: gap_f = 8;
                6: gap_f = 9;
                default: gap_f = 0;
            endcase
            cyc((i < 5) ? gap_pat[i] : 1'b0, gap_f, 0);
            check("gap_count", count, gap_cnt[i]);
        end
        check("gap_head", out_data, 7);

        // Mid-operation asynchronous reset with two entries and issues in flight.
        cyc(0, 0, 1);   check("ar_pre_count", count, 2);
        check("ar_pre_head", out_data, 8);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_count", count, 0);
        check("ar_ovf", overflow, 0);
        check("ar_data", out_data, 0);
        check("ar_full", full, 0);
        issue = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 333, 0);
            check("ar_stale_count", count, 0);
        end
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);   check("ar_post_e2", out_valid, 0);
        cyc(0, 444, 0);
        check("ar_post_count", count, 1);
        check("ar_post_data", out_data, 444);
        cyc(0, 0, 1);   check("ar_post_drain", out_valid, 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_result_fifo.md
# pipe_result_fifo

Downstream companion to the 3-stage arithmetic pipeline (F = ((A+B)+(C−D))·D). The pipeline carries no valid qualifier, so this block tracks which cycles issued real operands, delays that strobe by the pipeline latency, and captures the matching F values into a small first-word-fall-through FIFO. The FIFO presents results to the consumer with a ready/valid handshake and flags dropped results.

## Interface
- N, 10: data width; matches the pipeline's N.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- LAT, 3: pipeline latency in clock edges from operand sample to F valid; ≥1.
- clk  input  1  rising-edge clock, shared with the pipeline.
- rst  input  1  asynchronous, active-high reset.
- issue  input  1  high in a cycle where valid operands are presented to the pipeline (sampled at the same edge as stage 1).
- F  input  N  pipeline result.
- out_data  output  N  head entry; 0 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid && out_ready at a rising edge.
- count  output  $clog2(DEPTH+1)  entries held.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a result is dropped.

## Operation
- Tracker: LAT-bit shift register `trk`; each edge trk <= {trk[LAT-2:0], issue}. Write strobe wr = trk[LAT-1].
- wr at an edge captures F into mem[wr_ptr], and wr_ptr advances modulo DEPTH.
- rd = out_valid && out_ready; at an edge rd_ptr advances modulo DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally; count is tracked separately: +1 on accepted write only, −1 on read only, unchanged on both or neither.
- Write acceptance: accepted if !full, or if full && rd in the same edge (simultaneous read frees the slot).
- Write when full && !rd: F is dropped, nothing else changes, and overflow <= 1. Overflow clears only on rst.
- Read when empty: impossible, because out_valid = 0.
- out_data = mem[rd_ptr] when count != 0, else 0 (combinational mux, FWFT).
- Results leave in issue order; no reordering or merging.
- The pipeline has no reset. After rst deasserts, trk = 0 guarantees that stale F values in flight are never written.

## Timing
- Reset (asynchronous, immediate): trk = 0, wr_ptr = rd_ptr = 0, count = 0, overflow = 0, so out_valid = 0, out_data = 0, full = 0. mem is not reset.
- Latency: issue sampled at edge k means F is captured at edge k+LAT, and out_valid rises after edge k+LAT (FIFO was empty). Total issue-to-visible is LAT edges.
- Back-to-back issues produce one write per edge; sustained throughput is 1/cycle with out_ready held high.
- rst mid-operation: every entry and every in-flight tracked issue is discarded; the first valid write is LAT edges after the first post-reset issue.
- full, count and out_valid all update on the same edge as the pointer change; no extra cycle.

## Test plan
- Reset: assert rst asynchronously between edges with the FIFO holding 2 entries → out_valid, count, overflow and out_data read 0 immediately; a stale F on the next 3 edges is not captured.
- Latency: issue=1 for one cycle at edge 0, F=15 at edge 3, out_ready=0 → out_valid rises after edge 3 with out_data=15 and count=1; nothing is captured at edges 1–2.
- Ordering/wrap: 6 consecutive issues with F=15,70,288,1,2,3, out_ready=1 from edge 4 → out_data sequence 15,70,288,1,2,3, pointers wrap past 3 without loss, overflow stays 0.
- Full, no read: 5 consecutive issues, out_ready=0 → count=4, full=1, overflow=1 after the 5th write edge; the head remains the first value.
- Full with simultaneous read: FIFO full, out_ready=1 on the edge a 5th result arrives → write accepted, count stays 4, overflow stays 0, the new value appears last.
- Gapped issues: issue pattern 1,0,1,1,0 → exactly 3 writes, at edges 3, 5 and 6; count=3 with out_ready=0.
